// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Size codes, FSM states and access-legality checks.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic f3_illegal(
    input logic [2:0] f3
  );
    return (f3 == 3'b011) ||
           (f3 == 3'b110) ||
           (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic r;
    r = 1'b0;
    if (f3 == F3_H || f3 == F3_HU)
      r = lo[0];
    else if (f3 == F3_W)
      r = (lo != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and sizing/extension for loads.
// Purely combinational; the caller masks results on error.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        uns;
  logic [31:0] sh;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_w = (funct3 == F3_W);
  assign uns  = funct3[2];
  assign sh   = rword >> {addr_lo, 3'b000};

  always_comb begin
    be       = 4'b0000;
    wdata_sh = wdata;
    rdata    = 32'd0;
    unique case (1'b1)
      is_b: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = uns ? {24'd0, sh[7:0]}
                       : {{24{sh[7]}}, sh[7:0]};
      end
      is_h: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = uns ? {16'd0, sh[15:0]}
                       : {{16{sh[15]}}, sh[15:0]};
      end
      is_w: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
      default: begin
        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Load/store target with fixed wait-state latency and RV32I sizing.
// One transaction in flight; commit happens on the edge entering RESP.
module riscv_dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic          idle;
  logic          accept;
  logic          enter_resp;
  logic          in_range;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;

  logic [31:0] mem [DEPTH_WORDS];

  assign idle      = (state_q == S_IDLE);
  assign accept    = idle && req_valid;
  assign req_ready = idle;
  assign rsp_valid = (state_q == S_RESP);

  // With zero wait states the commit edge is the accept edge,
  // so the live request must be used instead of the latch.
  assign cur_we    = idle ? req_we     : lat_we;
  assign cur_f3    = idle ? req_funct3 : lat_f3;
  assign cur_addr  = idle ? req_addr   : lat_addr;
  assign cur_wdata = idle ? req_wdata  : lat_wdata;

  assign in_range =
    {2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS);
  assign err =
    f3_illegal(cur_f3) ||
    misaligned(cur_f3, cur_addr[1:0]) ||
    !in_range;

  assign idx   = cur_addr[AW+1:2];
  assign rword = mem[idx];

  assign enter_resp =
    (state_q != S_RESP) && (state_d == S_RESP);

  dmem_lane_align u_align (
    .funct3   (cur_f3),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready)
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_we) ? 32'd0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_f3    <= req_funct3;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Storage is never reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized scoreboard bench for riscv_dmem_responder.
// Byte-array reference model; second instance covers zero wait states.
module tb_riscv_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        rv_z, rr_z, we_z, sv_z, sr_z, se_z;
  logic [2:0]  f3_z;
  logic [31:0] ad_z, wd_z, sd_z;

  always #5 clk = ~clk;

  riscv_dmem_responder #(
    .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  riscv_dmem_responder #(
    .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv_z), .req_ready(rr_z),
    .req_we(we_z), .req_funct3(f3_z),
    .req_addr(ad_z), .req_wdata(wd_z),
    .rsp_valid(sv_z), .rsp_ready(sr_z),
    .rsp_rdata(sd_z), .rsp_err(se_z)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  bit hold = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [4*DEPTH];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, little-endian.
  function automatic exp_t model_op(input bit we,
                                    input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] wd);
    exp_t e;
    int size;
    bit bad;
    logic [31:0] v, mask;
    size = 1 << f3[1:0];
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
       || (a % size != 0) || (a >= 32'(4*DEPTH));
    e.rdata = 32'd0;
    e.err = bad;
    e.vcyc = 0;
    if (bad) return e;
    if (we) begin
      for (int i = 0; i < size; i++)
        mb[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++)
        v = v | (32'(mb[a+i]) << (8*i));
      if (size < 4) begin
        mask = (32'd1 << (8*size)) - 32'd1;
        if (!f3[2] && v[8*size-1]) v = v | ~mask;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // Called and returns at a negedge.
  task automatic issue(input bit we, input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input bit track);
    bit ok = 1'b0;
    int k = 0;
    exp_t e;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    for (int n = 0; n < 300; n++) begin
      if (req_ready) begin
        ok = 1'b1;
        k = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL issue_timeout: addr %h not accepted", a);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e = model_op(we, f3, a, wd);
      e.vcyc = k + 1 + WC;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d responses pending",
               q.size());
      q.delete();
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  bit seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: rdata %h err %b",
                   rsp_rdata, rsp_err);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(q[0].vcyc));
            seen = 1'b1;
          end
          chk("rdata", rsp_rdata, q[0].rdata);
          chk("err", 32'(rsp_err), 32'(q[0].err));
          chk("busy_ready", 32'(req_ready), 32'd0);
          if (rsp_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    rv_z = 1'b0; we_z = 1'b0; f3_z = 3'd0;
    ad_z = 32'd0; wd_z = 32'd0; sr_z = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_z_ready", 32'(rr_z), 32'd1);

    for (int w = 0; w < 16; w++)
      issue(1'b1, 3'd2, 32'(4*w), $urandom, 1'b1);

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    issue(1'b0, 3'd0, 32'h13, 32'd0, 1'b1);
    issue(1'b0, 3'd4, 32'h13, 32'd0, 1'b1);
    issue(1'b0, 3'd1, 32'h10, 32'd0, 1'b1);
    issue(1'b0, 3'd5, 32'h12, 32'd0, 1'b1);
    issue(1'b1, 3'd0, 32'h11, 32'h55, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    issue(1'b1, 3'd1, 32'h12, 32'h1234, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'h11, 32'd0, 1'b1);
    issue(1'b1, 3'd1, 32'h13, 32'hFFFF, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'(4*DEPTH), 32'd0, 1'b1);
    issue(1'b0, 3'd3, 32'h10, 32'd0, 1'b1);
    drain();

    hold = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    fork
      issue(1'b0, 3'd5, 32'h12, 32'd0, 1'b1);
      begin
        for (int n = 0; n < 20 && !rsp_valid; n++)
          @(negedge clk);
        for (int n = 0; n < 5; n++) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_rdata", rsp_rdata, 32'h123455EF);
          chk("hold_ready", 32'(req_ready), 32'd0);
          @(negedge clk);
        end
        hold = 1'b0;
      end
    join
    drain();

    issue(1'b1, 3'd2, 32'h20, 32'hAAAAAAAA, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(1'b0, 3'd2, 32'h20, 32'd0, 1'b1);
    drain();

    for (int t = 0; t < 150; t++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      we = $urandom_range(1) == 1;
      f3 = we ? 3'($urandom_range(2)) : 3'($urandom_range(7));
      a = 32'($urandom_range(63));
      if ($urandom_range(11) == 0)
        a = 32'(4*DEPTH) + 32'($urandom_range(15));
      issue(we, f3, a, $urandom, 1'b1);
    end
    drain();

    rv_z = 1'b1; we_z = 1'b1; f3_z = 3'd2;
    ad_z = 32'h4; wd_z = 32'h12345678;
    chk("z_ready", 32'(rr_z), 32'd1);
    @(negedge clk);
    chk("z_st_valid", 32'(sv_z), 32'd1);
    chk("z_st_err", 32'(se_z), 32'd0);
    we_z = 1'b0;
    @(negedge clk);
    chk("z_idle_valid", 32'(sv_z), 32'd0);
    chk("z_idle_ready", 32'(rr_z), 32'd1);
    @(negedge clk);
    chk("z_ld_valid", 32'(sv_z), 32'd1);
    chk("z_ld_rdata", sd_z, 32'h12345678);
    f3_z = 3'd1; ad_z = 32'h5;
    @(negedge clk);
    @(negedge clk);
    chk("z_mis_valid", 32'(sv_z), 32'd1);
    chk("z_mis_err", 32'(se_z), 32'd1);
    chk("z_mis_rdata", sd_z, 32'd0);
    rv_z = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
